// File: rtl/ctrl_seq.sv
// Multi-cycle instruction sequencer: latches one instruction per handshake and drives
// datapath control through IDLE/EXEC/MEM/HALT, with memory timeout and error counting.
module ctrl_seq #(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 5,
  parameter int REG_AW = 4,
  parameter int IMM_W  = 16,
  parameter int MEM_TO = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic              zero_i,
  input  logic              mem_ack_i,
  output logic              mem_req_o,
  output logic              load_en_o,
  output logic              write_en_o,
  output logic              data_sel_o,
  output logic              const_sel_o,
  output logic [3:0]        op_sel_o,
  output logic [REG_AW-1:0] a_sel_o,
  output logic [REG_AW-1:0] b_sel_o,
  output logic [REG_AW-1:0] dest_sel_o,
  output logic [IMM_W-1:0]  const_in_o,
  output logic              pc_load_o,
  output logic              offset_sel_o,
  output logic              halted_o,
  output logic              illegal_o,
  output logic              mem_err_o,
  output logic [7:0]        err_cnt_o
);

  localparam int WAIT_W = $clog2(MEM_TO + 1);
  localparam int DST_HI = DATA_W - OPC_W - 1;
  localparam int A_HI   = DST_HI - REG_AW;
  localparam int B_HI   = A_HI - REG_AW;

  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_MOVA = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_NOT  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_ADI  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_SBI  = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_ANI  = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_XRI  = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_MOVB = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_LSR  = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_LSL  = OPC_W'(15);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(16);
  localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(17);
  localparam logic [OPC_W-1:0] OP_JMR  = OPC_W'(18);
  localparam logic [OPC_W-1:0] OP_BZ   = OPC_W'(19);
  localparam logic [OPC_W-1:0] OP_BNZ  = OPC_W'(20);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(21);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(22);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_MEM = 2'd2, S_HALT = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [7:0]          err_q, err_d;

  logic [OPC_W-1:0]    opc_s;
  logic                dec_load_s, dec_ld_s, dec_st_s, dec_pc_s, dec_jmr_s, dec_halt_s, dec_ill_s;
  logic                ir_unused_s;

  assign opc_s       = ir_q[DATA_W-1 -: OPC_W];
  assign err_cnt_o   = err_q;
  assign ir_unused_s = ^ir_q;

  // Opcode decode: ALU controls, field overrides and per-class flags from IR.
  always_comb begin
    op_sel_o    = 4'b0000;
    const_sel_o = 1'b0;
    a_sel_o     = ir_q[A_HI -: REG_AW];
    b_sel_o     = ir_q[B_HI -: REG_AW];
    dest_sel_o  = ir_q[DST_HI -: REG_AW];
    const_in_o  = ir_q[B_HI -: IMM_W];
    dec_load_s  = 1'b0;
    dec_ld_s    = 1'b0;
    dec_st_s    = 1'b0;
    dec_pc_s    = 1'b0;
    dec_jmr_s   = 1'b0;
    dec_halt_s  = 1'b0;
    dec_ill_s   = 1'b0;
    case (opc_s)
      OP_NOP: begin
        a_sel_o    = {REG_AW{1'b0}};
        b_sel_o    = {REG_AW{1'b0}};
        dest_sel_o = {REG_AW{1'b0}};
        const_in_o = {IMM_W{1'b0}};
      end
      OP_ADD: begin op_sel_o = 4'b0000; dec_load_s = 1'b1; end
      OP_SUB: begin op_sel_o = 4'b0001; dec_load_s = 1'b1; end
      OP_AND: begin op_sel_o = 4'b0100; dec_load_s = 1'b1; end
      OP_OR:  begin op_sel_o = 4'b0101; dec_load_s = 1'b1; end
      OP_XOR: begin op_sel_o = 4'b0110; dec_load_s = 1'b1; end
      OP_NOT: begin op_sel_o = 4'b0111; dec_load_s = 1'b1; end
      OP_LSR: begin op_sel_o = 4'b1001; dec_load_s = 1'b1; end
      OP_LSL: begin op_sel_o = 4'b1000; dec_load_s = 1'b1; end
      OP_ADI, OP_SBI, OP_ANI, OP_ORI, OP_XRI, OP_MOVA: begin
        const_sel_o = 1'b1;
        b_sel_o     = {REG_AW{1'b0}};
        dec_load_s  = 1'b1;
        case (opc_s)
          OP_ADI:  op_sel_o = 4'b0000;
          OP_SBI:  op_sel_o = 4'b0001;
          OP_ANI:  op_sel_o = 4'b0100;
          OP_XRI:  op_sel_o = 4'b0110;
          default: op_sel_o = 4'b0101;
        endcase
      end
      // MOVB routes B through the A port by swapping selects and ORing with zero.
      OP_MOVB: begin
        a_sel_o     = ir_q[B_HI -: REG_AW];
        b_sel_o     = ir_q[A_HI -: REG_AW];
        const_in_o  = {IMM_W{1'b0}};
        const_sel_o = 1'b1;
        op_sel_o    = 4'b0101;
        dec_load_s  = 1'b1;
      end
      OP_LD:   dec_ld_s = 1'b1;
      OP_ST:   dec_st_s = 1'b1;
      OP_JMR:  begin dec_pc_s = 1'b1; dec_jmr_s = 1'b1; end
      OP_BZ:   dec_pc_s = zero_i;
      OP_BNZ:  dec_pc_s = ~zero_i;
      OP_JMP:  dec_pc_s = 1'b1;
      OP_HALT: dec_halt_s = 1'b1;
      default: dec_ill_s = 1'b1;
    endcase
  end

  // Next-state and strobe logic; strobes default low outside their owning states.
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    wait_d        = wait_q;
    err_d         = err_q;
    instr_ready_o = 1'b0;
    mem_req_o     = 1'b0;
    write_en_o    = 1'b0;
    load_en_o     = 1'b0;
    data_sel_o    = 1'b0;
    pc_load_o     = 1'b0;
    offset_sel_o  = 1'b0;
    illegal_o     = 1'b0;
    mem_err_o     = 1'b0;
    halted_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) begin
          ir_d    = instr_i;
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        load_en_o    = dec_load_s;
        pc_load_o    = dec_pc_s;
        offset_sel_o = dec_jmr_s;
        illegal_o    = dec_ill_s;
        if (dec_ld_s || dec_st_s) begin
          mem_req_o  = 1'b1;
          write_en_o = dec_st_s;
          wait_d     = {WAIT_W{1'b0}};
          state_d    = S_MEM;
        end else if (dec_halt_s) begin
          state_d = S_HALT;
        end else begin
          state_d = S_IDLE;
        end
      end
      // An ack in the final wait cycle takes precedence over the timeout.
      S_MEM: begin
        mem_req_o  = 1'b1;
        write_en_o = dec_st_s;
        data_sel_o = dec_ld_s;
        if (mem_ack_i) begin
          load_en_o = dec_ld_s;
          state_d   = S_IDLE;
        end else if (wait_q == WAIT_W'(MEM_TO - 1)) begin
          mem_err_o = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_HALT: begin
        halted_o = 1'b1;
        state_d  = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
    if ((illegal_o || mem_err_o) && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end else begin
      err_d = err_q;
    end
  end

  // State, instruction register, wait counter and error counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ir_q    <= {DATA_W{1'b0}};
      wait_q  <= {WAIT_W{1'b0}};
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: table-driven single-cycle instructions through a
// scoreboard queue, plus hand-written LD/ST/timeout/HALT/reset/saturation sequences.
module tb_ctrl_seq;

  logic        clk, rst, instr_valid, instr_ready, zero, mem_ack;
  logic [31:0] instr;
  logic        mem_req, load_en, write_en, data_sel, const_sel, pc_load, offset_sel;
  logic        halted, illegal, mem_err;
  logic [3:0]  op_sel, a_sel, b_sel, dest_sel;
  logic [15:0] const_in;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  ctrl_seq dut (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .instr_valid_i(instr_valid),
    .instr_ready_o(instr_ready), .zero_i(zero), .mem_ack_i(mem_ack),
    .mem_req_o(mem_req), .load_en_o(load_en), .write_en_o(write_en),
    .data_sel_o(data_sel), .const_sel_o(const_sel), .op_sel_o(op_sel),
    .a_sel_o(a_sel), .b_sel_o(b_sel), .dest_sel_o(dest_sel), .const_in_o(const_in),
    .pc_load_o(pc_load), .offset_sel_o(offset_sel), .halted_o(halted),
    .illegal_o(illegal), .mem_err_o(mem_err), .err_cnt_o(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  opc;
    logic [3:0]  d;
    logic [3:0]  a;
    logic [15:0] imm;
    logic        zero;
    logic        e_load;
    logic        e_pc;
    logic        e_off;
    logic        e_ill;
    logic [3:0]  e_op;
    logic        e_cs;
    logic [3:0]  e_a;
    logic [3:0]  e_b;
    logic [3:0]  e_d;
    logic [15:0] e_k;
  } vec_t;

  localparam int NV = 24;
  vec_t vt [0:NV-1];
  vec_t sb [$];

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [3:0] d,
                                     input logic [3:0] a, input logic [15:0] imm);
    mk = {opc, d, a, imm, 3'b000};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    int   req_cnt, err_cyc;
    logic got_idle, saw_load;

    //          opc    d     a     imm       z     ld    pc    off   ill   op       cs    ea    eb    ed    ek
    vt[0]  = '{5'd2,  4'd3, 4'd1, 16'h2000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd1, 4'd2, 4'd3, 16'h2000};
    vt[1]  = '{5'd3,  4'd5, 4'd6, 16'h7abc, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 4'd6, 4'd7, 4'd5, 16'h7abc};
    vt[2]  = '{5'd4,  4'd1, 4'd2, 16'h3000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 4'd2, 4'd3, 4'd1, 16'h3000};
    vt[3]  = '{5'd5,  4'd8, 4'd9, 16'ha001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b0, 4'd9, 4'd10,4'd8, 16'ha001};
    vt[4]  = '{5'd6,  4'd1, 4'd2, 16'h3000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0, 4'd2, 4'd3, 4'd1, 16'h3000};
    vt[5]  = '{5'd7,  4'd4, 4'd5, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0111, 1'b0, 4'd5, 4'd0, 4'd4, 16'h0000};
    vt[6]  = '{5'd14, 4'd2, 4'd3, 16'hc000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b0, 4'd3, 4'd12,4'd2, 16'hc000};
    vt[7]  = '{5'd15, 4'd2, 4'd3, 16'hd000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 4'd3, 4'd13,4'd2, 16'hd000};
    vt[8]  = '{5'd8,  4'd4, 4'd9, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'd9, 4'd0, 4'd4, 16'h1234};
    vt[9]  = '{5'd9,  4'd1, 4'd1, 16'hffff, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 4'd1, 4'd0, 4'd1, 16'hffff};
    vt[10] = '{5'd10, 4'd2, 4'd2, 16'h0f0f, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 4'd2, 4'd0, 4'd2, 16'h0f0f};
    vt[11] = '{5'd11, 4'd2, 4'd3, 16'habcd, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b1, 4'd3, 4'd0, 4'd2, 16'habcd};
    vt[12] = '{5'd12, 4'd3, 4'd4, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b1, 4'd4, 4'd0, 4'd3, 16'h5555};
    vt[13] = '{5'd1,  4'd7, 4'd8, 16'h0042, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b1, 4'd8, 4'd0, 4'd7, 16'h0042};
    vt[14] = '{5'd13, 4'd6, 4'd4, 16'h9000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b1, 4'd9, 4'd4, 4'd6, 16'h0000};
    vt[15] = '{5'd0,  4'd5, 4'd5, 16'hffff, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0, 4'd0, 4'd0, 16'h0000};
    vt[16] = '{5'd19, 4'd2, 4'd3, 16'h4000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd3, 4'd4, 4'd2, 16'h4000};
    vt[17] = '{5'd19, 4'd2, 4'd3, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd3, 4'd4, 4'd2, 16'h4000};
    vt[18] = '{5'd20, 4'd2, 4'd3, 16'h4000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd3, 4'd4, 4'd2, 16'h4000};
    vt[19] = '{5'd20, 4'd2, 4'd3, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd3, 4'd4, 4'd2, 16'h4000};
    vt[20] = '{5'd21, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0, 4'd0, 4'd0, 16'h0000};
    vt[21] = '{5'd18, 4'd1, 4'd2, 16'h3000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd2, 4'd3, 4'd1, 16'h3000};
    vt[22] = '{5'd31, 4'd1, 4'd1, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'd1, 4'd1, 4'd1, 16'h1000};
    vt[23] = '{5'd23, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'd0, 4'd0, 4'd0, 16'h0000};

    rst = 1'b1; instr_valid = 1'b0; instr = 32'd0; zero = 1'b0; mem_ack = 1'b0;
    step(); step();
    chk("rst.ready",   {31'd0, instr_ready}, 32'd1);
    chk("rst.err_cnt", {24'd0, err_cnt},     32'd0);
    chk("rst.halted",  {31'd0, halted},      32'd0);
    chk("rst.strobes", {26'd0, mem_req, load_en, write_en, pc_load, illegal, mem_err}, 32'd0);
    chk("rst.fields",  {a_sel, b_sel, dest_sel, const_in}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst.ready", {31'd0, instr_ready}, 32'd1);

    // mem_ack outside MEM must have no effect
    mem_ack = 1'b1;
    #1;
    chk("idle_ack.strobes", {29'd0, load_en, mem_req, mem_err}, 32'd0);
    step();
    chk("idle_ack.ready", {31'd0, instr_ready}, 32'd1);
    mem_ack = 1'b0;

    for (int i = 0; i < NV; i++) begin
      zero = vt[i].zero;
      instr = mk(vt[i].opc, vt[i].d, vt[i].a, vt[i].imm);
      instr_valid = 1'b1;
      sb.push_back(vt[i]);
      if (vt[i].e_ill) exp_err++;
      step();
      instr_valid = 1'b0;
      v = sb.pop_front();
      chk($sformatf("v%0d.load", i),    {31'd0, load_en},    {31'd0, v.e_load});
      chk($sformatf("v%0d.pc", i),      {31'd0, pc_load},    {31'd0, v.e_pc});
      chk($sformatf("v%0d.off", i),     {31'd0, offset_sel}, {31'd0, v.e_off});
      chk($sformatf("v%0d.ill", i),     {31'd0, illegal},    {31'd0, v.e_ill});
      chk($sformatf("v%0d.op", i),      {28'd0, op_sel},     {28'd0, v.e_op});
      chk($sformatf("v%0d.cs", i),      {31'd0, const_sel},  {31'd0, v.e_cs});
      chk($sformatf("v%0d.sel", i),     {20'd0, a_sel, b_sel, dest_sel}, {20'd0, v.e_a, v.e_b, v.e_d});
      chk($sformatf("v%0d.k", i),       {16'd0, const_in},   {16'd0, v.e_k});
      chk($sformatf("v%0d.mem", i),     {29'd0, mem_req, write_en, mem_err}, 32'd0);
      chk($sformatf("v%0d.busy", i),    {31'd0, instr_ready}, 32'd0);
      step();
      chk($sformatf("v%0d.ready", i),   {31'd0, instr_ready}, 32'd1);
      chk($sformatf("v%0d.quiet", i),   {29'd0, load_en, pc_load, illegal}, 32'd0);
      chk($sformatf("v%0d.err_cnt", i), {24'd0, err_cnt}, exp_err);
    end
    zero = 1'b0;

    // LD: ack after 3 wait cycles; a competing instr_valid during MEM is ignored
    instr = mk(5'd16, 4'd3, 4'd1, 16'h0010);
    instr_valid = 1'b1;
    step();
    instr = mk(5'd2, 4'd15, 4'd15, 16'hf000);
    chk("ld.exec", {28'd0, mem_req, write_en, load_en, instr_ready}, 32'b1000);
    req_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (mem_req) req_cnt++;
      chk($sformatf("ld.wait%0d", c), {29'd0, data_sel, load_en, instr_ready}, 32'b100);
    end
    step();
    mem_ack = 1'b1;
    #1;
    if (mem_req) req_cnt++;
    chk("ld.ack", {29'd0, data_sel, load_en, write_en}, 32'b110);
    chk("ld.req_cycles", req_cnt, 32'd4);
    step();
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    chk("ld.done", {28'd0, instr_ready, mem_req, load_en, mem_err}, 32'b1000);
    chk("ld.no_capture", {28'd0, dest_sel}, 32'd3);

    // ST with no ack: timeout in the 15th MEM cycle
    instr = mk(5'd17, 4'd2, 4'd4, 16'h0000);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("st.exec", {29'd0, mem_req, write_en, load_en}, 32'b110);
    req_cnt = 0; err_cyc = 0; got_idle = 1'b0; saw_load = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (instr_ready) begin
        got_idle = 1'b1;
        break;
      end
      if (mem_req && write_en) req_cnt++;
      if (mem_err) err_cyc = c;
      if (load_en) saw_load = 1'b1;
    end
    exp_err++;
    chk("st_to.returned", {31'd0, got_idle}, 32'd1);
    chk("st_to.err_cycle", err_cyc, 32'd15);
    chk("st_to.req_cycles", req_cnt, 32'd15);
    chk("st_to.no_load", {31'd0, saw_load}, 32'd0);
    chk("st_to.idle", {29'd0, mem_req, write_en, mem_err}, 32'd0);
    chk("st_to.err_cnt", {24'd0, err_cnt}, exp_err);

    // ST with ack in the last wait cycle: ack wins, no error
    instr = mk(5'd17, 4'd2, 4'd4, 16'h0000);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    repeat (15) step();
    chk("st_ack.still_mem", {31'd0, instr_ready}, 32'd0);
    mem_ack = 1'b1;
    #1;
    chk("st_ack.last", {29'd0, mem_err, mem_req, write_en}, 32'b011);
    step();
    mem_ack = 1'b0;
    chk("st_ack.idle", {29'd0, instr_ready, mem_req, write_en}, 32'b100);
    chk("st_ack.err_cnt", {24'd0, err_cnt}, exp_err);

    // HALT sticks until reset and ignores instr_valid
    instr = mk(5'd22, 4'd0, 4'd0, 16'h0000);
    instr_valid = 1'b1;
    step();
    instr = mk(5'd2, 4'd1, 4'd1, 16'h1000);
    step();
    chk("halt.enter", {30'd0, halted, instr_ready}, 32'b10);
    repeat (5) step();
    chk("halt.hold", {29'd0, halted, instr_ready, load_en}, 32'b100);
    instr_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("halt.rst", {30'd0, halted, instr_ready}, 32'b01);
    chk("halt.rst_err", {24'd0, err_cnt}, 32'd0);

    // Reset in the middle of a LD wait
    instr = mk(5'd16, 4'd3, 4'd1, 16'h0000);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step(); step();
    chk("rst_mem.in_mem", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mem.after", {28'd0, mem_req, write_en, load_en, instr_ready}, 32'b0001);

    // err_cnt saturates at 255
    for (int n = 0; n < 260; n++) begin
      instr = mk(5'd31, 4'd0, 4'd0, 16'h0000);
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      step();
    end
    chk("sat.err_cnt", {24'd0, err_cnt}, 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
